// File: rtl/irq_prio_controller.sv
// Prioritised N-channel interrupt controller: edge/level capture, enable mask,
// lowest-index-first encode and a post-acknowledge hold-off on int_rq.
module irq_prio_controller #(
    parameter int N_IRQ   = 16,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int HOLDOFF = 15,
    parameter int TMR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              wren,
    input  logic [1:0]        reg_addr,
    input  logic [DATA_W-1:0] from_cpu,
    input  logic [N_IRQ-1:0]  irq_in,
    output logic [DATA_W-1:0] to_cpu,
    output logic [ADDR_W-1:0] int_addr,
    output logic              int_rq
);

    localparam logic [TMR_W-1:0] HOLD = TMR_W'(HOLDOFF);

    logic [N_IRQ-1:0]  status_q, status_d;
    logic [N_IRQ-1:0]  enable_q, enable_d;
    logic [N_IRQ-1:0]  mode_q, mode_d;
    logic [N_IRQ-1:0]  prev_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] to_cpu_q, to_cpu_d;
    logic [ADDR_W-1:0] int_addr_q, int_addr_d;
    logic              int_rq_q, int_rq_d;

    logic [N_IRQ-1:0]  trig;
    logic [N_IRQ-1:0]  active;
    logic [N_IRQ-1:0]  wdata;
    logic [ADDR_W-1:0] pri_idx;
    logic [DATA_W-1:0] vec;
    logic [DATA_W-1:0] rd_mux;
    logic              wr_status, wr_enable, wr_mode;
    logic              wdata_unused;

    // Upper write-data bits beyond the channel count are intentionally dropped
    assign wdata        = from_cpu[N_IRQ-1:0];
    assign wdata_unused = ^from_cpu;

    assign wr_status = ce & wren & (reg_addr == 2'd0);
    assign wr_enable = ce & wren & (reg_addr == 2'd1);
    assign wr_mode   = ce & wren & (reg_addr == 2'd2);

    // Level channels trigger while high; edge channels only on a 0->1 step
    assign trig   = irq_in & (mode_q | ~prev_q);
    assign active = status_q & enable_q;

    always_comb begin
        pri_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                pri_idx = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        status_d = status_q | trig;
        if (wr_status) begin
            status_d = (status_q & wdata) | trig;
        end
    end

    assign enable_d = wr_enable ? wdata : enable_q;
    assign mode_d   = wr_mode ? wdata : mode_q;

    always_comb begin
        timer_d = timer_q;
        if (wr_status) begin
            timer_d = HOLD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    assign int_rq_d   = (timer_q == '0) & (|active);
    assign int_addr_d = (|active) ? pri_idx : int_addr_q;

    always_comb begin
        vec               = '0;
        vec[DATA_W-1]     = int_rq_q;
        vec[ADDR_W-1:0]   = int_addr_q;
    end

    always_comb begin
        rd_mux = '0;
        unique case (reg_addr)
            2'd0: rd_mux = DATA_W'(status_q);
            2'd1: rd_mux = DATA_W'(enable_q);
            2'd2: rd_mux = DATA_W'(mode_q);
            2'd3: rd_mux = vec;
            default: rd_mux = '0;
        endcase
    end

    assign to_cpu_d = ce ? rd_mux : to_cpu_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q   <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            prev_q     <= '1;
            timer_q    <= '0;
            to_cpu_q   <= '0;
            int_addr_q <= '0;
            int_rq_q   <= 1'b0;
        end else begin
            status_q   <= status_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            prev_q     <= irq_in;
            timer_q    <= timer_d;
            to_cpu_q   <= to_cpu_d;
            int_addr_q <= int_addr_d;
            int_rq_q   <= int_rq_d;
        end
    end

    assign to_cpu   = to_cpu_q;
    assign int_addr = int_addr_q;
    assign int_rq   = int_rq_q;

endmodule

// File: tb/tb_irq_prio_controller.sv
// Scoreboard bench for irq_prio_controller: default build plus an
// 8-channel, zero hold-off build sharing one register bus.
module tb_irq_prio_controller;

    logic        clk = 1'b0;
    logic        rst, ce, wren;
    logic [1:0]  reg_addr;
    logic [15:0] from_cpu, irq;
    logic [15:0] rd0, rd1;
    logic [3:0]  ia0, ia1;
    logic        rq0, rq1;

    always #5 clk = ~clk;

    irq_prio_controller u0 (
        .clk(clk), .rst(rst), .ce(ce), .wren(wren),
        .reg_addr(reg_addr), .from_cpu(from_cpu), .irq_in(irq),
        .to_cpu(rd0), .int_addr(ia0), .int_rq(rq0)
    );

    irq_prio_controller #(.N_IRQ(8), .HOLDOFF(0)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .wren(wren),
        .reg_addr(reg_addr), .from_cpu(from_cpu), .irq_in(irq[7:0]),
        .to_cpu(rd1), .int_addr(ia1), .int_rq(rq1)
    );

    typedef struct {
        string       tag;
        logic [15:0] exp;
        bit          d1;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(string tag, logic [15:0] exp, bit d1);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        e.d1  = d1;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 16'h0001, 16'h0000);
        end else begin
            e = sb.pop_front();
            chk(e.tag, e.d1 ? rd1 : rd0, e.exp);
        end
    endtask

    task automatic idle(int n);
        ce   = 1'b0;
        wren = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [15:0] d);
        ce       = 1'b1;
        wren     = 1'b1;
        reg_addr = a;
        from_cpu = d;
        @(negedge clk);
        ce   = 1'b0;
        wren = 1'b0;
    endtask

    task automatic rd(string tag, logic [1:0] a, logic [15:0] exp, bit d1);
        ce       = 1'b1;
        wren     = 1'b0;
        reg_addr = a;
        push(tag, exp, d1);
        @(negedge clk);
        ce = 1'b0;
        collect();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        ce       = 1'b0;
        wren     = 1'b0;
        reg_addr = 2'd0;
        from_cpu = '0;
        irq      = 16'hFFFF;
        idle(3);
        chk("rst_rq", rq0, 0);
        chk("rst_addr", ia0, 0);
        chk("rst_rd", rd0, 0);
        rst = 1'b1;

        // lines high across reset release must not edge-trigger
        wr(2'd1, 16'hFFFF);
        idle(3);
        chk("noedge_rq", rq0, 0);
        rd("noedge_status", 2'd0, 16'h0000, 1'b0);
        wr(2'd1, 16'h0000);
        irq = '0;
        idle(2);

        wr(2'd1, 16'h0024);
        irq = 16'h0020;
        idle(1);
        irq = 16'h0004;
        idle(1);
        chk("edge_addr5", ia0, 5);
        irq = '0;
        idle(1);
        chk("edge_addr2", ia0, 2);
        chk("edge_rq", rq0, 1);
        rd("edge_status", 2'd0, 16'h0024, 1'b0);

        wr(2'd0, 16'hFFFB);
        chk("ho_first", rq0, 1);
        for (int i = 0; i < 15; i++) begin
            idle(1);
            chk("ho_low", rq0, 0);
        end
        idle(1);
        chk("ho_exp_rq", rq0, 1);
        chk("ho_exp_addr", ia0, 5);
        wr(2'd0, 16'h0000);
        idle(16);

        wr(2'd2, 16'h0001);
        wr(2'd1, 16'h0001);
        irq = 16'h0001;
        idle(2);
        wr(2'd0, 16'hFFFE);
        rd("lvl_repend", 2'd0, 16'h0001, 1'b0);
        chk("lvl_ho", rq0, 0);
        idle(15);
        chk("lvl_rq", rq0, 1);
        chk("lvl_addr", ia0, 0);
        irq = '0;
        wr(2'd2, 16'h0000);
        wr(2'd0, 16'h0000);
        idle(16);

        irq = 16'h0080;
        wr(2'd0, 16'h0000);
        rd("race", 2'd0, 16'h0080, 1'b0);
        idle(16);
        chk("dis_pend_rq", rq0, 0);
        wr(2'd1, 16'h0080);
        chk("en_late_pre", rq0, 0);
        idle(1);
        chk("en_late_rq", rq0, 1);
        chk("en_late_addr", ia0, 7);
        rd("vec7", 2'd3, 16'h8007, 1'b0);

        irq = 16'h008A;
        wr(2'd1, 16'h008A);
        idle(1);
        chk("multi_first", ia0, 1);
        wr(2'd0, 16'hFFFD);
        idle(16);
        chk("multi_next", ia0, 3);
        rd("vec3", 2'd3, 16'h8003, 1'b0);

        wr(2'd0, 16'h0000);
        rst = 1'b0;
        idle(2);
        chk("rst_abort_rq", rq0, 0);
        chk("rst_abort_rd", rd0, 0);
        rst = 1'b1;

        wr(2'd1, 16'hFFFF);
        rd("ro_enable", 2'd1, 16'h00FF, 1'b1);
        irq = '0;
        idle(1);
        irq = 16'h0012;
        idle(1);
        irq = '0;
        idle(1);
        chk("h0_rq", rq1, 1);
        chk("h0_addr", ia1, 1);
        push("h0_prewr", 16'h0012, 1'b1);
        wr(2'd0, 16'hFFFD);
        collect();
        chk("h0_w", rq1, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("h0_hold", rq1, 1);
        end
        chk("h0_addr4", ia1, 4);
        rd("vec4", 2'd3, 16'h8004, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
